// File: rtl/softex_addmul_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | softex_addmul_arbiter: shares the vector add/mul FMA datapath between the   |
// | ADD and MUL channels using burst-limited fairness and per-op credits.       |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+

package softex_pkg;
    typedef enum logic [0:0] {ADD = 1'b0, MUL = 1'b1} operation_t;
endpackage

module softex_addmul_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int CREDITS   = 4,
    localparam int CNT_W    = $clog2(CREDITS + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  enable_i,
    input  logic                  prio_mode_i,
    input  softex_pkg::operation_t prio_op_i,
    input  logic                  add_req_i,
    input  logic                  mul_req_i,
    input  logic                  fma_ready_i,
    input  logic                  add_done_i,
    input  logic                  mul_done_i,
    output softex_pkg::operation_t operation_o,
    output logic                  issue_en_o,
    output logic [CNT_W-1:0]      add_inflight_o,
    output logic [CNT_W-1:0]      mul_inflight_o,
    output logic                  busy_o
);
    import softex_pkg::*;

    localparam int BURST_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]   CREDITS_C   = CNT_W'(CREDITS);
    localparam logic [BURST_W-1:0] MAX_BURST_C = BURST_W'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT_ADD = 2'd1,
        GRANT_MUL = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
    operation_t         last_op_q, last_op_d;
    logic [CNT_W-1:0]   add_cnt_q, add_cnt_d;
    logic [CNT_W-1:0]   mul_cnt_q, mul_cnt_d;

    logic       granted_add, granted_mul;
    logic       add_credit, mul_credit;
    logic       accept_add, accept_mul;
    logic       x_is_mul, x_req, y_req, x_credit, y_credit, accept_x;
    operation_t x_op, y_op;
    state_t     y_state;

    assign granted_add = (state_q == GRANT_ADD);
    assign granted_mul = (state_q == GRANT_MUL);
    assign add_credit  = (add_cnt_q < CREDITS_C);
    assign mul_credit  = (mul_cnt_q < CREDITS_C);

    assign issue_en_o  = enable_i & ((granted_add & add_credit) | (granted_mul & mul_credit));
    assign operation_o = granted_mul ? MUL : ADD;
    assign accept_add  = granted_add & add_req_i & fma_ready_i & issue_en_o;
    assign accept_mul  = granted_mul & mul_req_i & fma_ready_i & issue_en_o;

    // Granted op (X) and the competing op (Y), valid while in a GRANT state.
    assign x_is_mul = granted_mul;
    assign x_req    = x_is_mul ? mul_req_i  : add_req_i;
    assign y_req    = x_is_mul ? add_req_i  : mul_req_i;
    assign x_credit = x_is_mul ? mul_credit : add_credit;
    assign y_credit = x_is_mul ? add_credit : mul_credit;
    assign accept_x = x_is_mul ? accept_mul : accept_add;
    assign x_op     = x_is_mul ? MUL : ADD;
    assign y_op     = x_is_mul ? ADD : MUL;
    assign y_state  = x_is_mul ? GRANT_ADD : GRANT_MUL;

    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        last_op_d   = last_op_q;
        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    if (add_req_i && mul_req_i) begin
                        if (prio_mode_i) begin
                            state_d = (prio_op_i == MUL) ? GRANT_MUL : GRANT_ADD;
                        end else begin
                            state_d = (last_op_q == MUL) ? GRANT_ADD : GRANT_MUL;
                        end
                    end else if (add_req_i) begin
                        state_d = GRANT_ADD;
                    end else if (mul_req_i) begin
                        state_d = GRANT_MUL;
                    end
                end
            end
            GRANT_ADD, GRANT_MUL: begin
                if (x_req && !accept_x && issue_en_o) begin
                    // An offered but unaccepted transfer must keep its op select.
                    state_d = state_q;
                end else if (x_req && !x_credit && y_req && y_credit) begin
                    state_d     = y_state;
                    burst_cnt_d = '0;
                end else if (accept_x && y_req &&
                             (prio_mode_i ? (y_op == prio_op_i)
                                          : (burst_cnt_q >= MAX_BURST_C - BURST_W'(1)))) begin
                    state_d     = y_state;
                    burst_cnt_d = '0;
                    last_op_d   = x_op;
                end else if (accept_x) begin
                    if (burst_cnt_q != MAX_BURST_C) begin
                        burst_cnt_d = burst_cnt_q + BURST_W'(1);
                    end
                end else if (!x_req && y_req) begin
                    state_d     = y_state;
                    burst_cnt_d = '0;
                end else if (!x_req && !y_req) begin
                    state_d     = IDLE;
                    burst_cnt_d = '0;
                end
            end
            default: begin
                state_d     = IDLE;
                burst_cnt_d = '0;
            end
        endcase
    end

    // Done pulses with nothing outstanding are dropped rather than wrapping.
    always_comb begin
        add_cnt_d = add_cnt_q;
        case ({accept_add, add_done_i})
            2'b10:   add_cnt_d = add_cnt_q + CNT_W'(1);
            2'b01:   if (add_cnt_q != '0) add_cnt_d = add_cnt_q - CNT_W'(1);
            default: add_cnt_d = add_cnt_q;
        endcase
    end

    always_comb begin
        mul_cnt_d = mul_cnt_q;
        case ({accept_mul, mul_done_i})
            2'b10:   mul_cnt_d = mul_cnt_q + CNT_W'(1);
            2'b01:   if (mul_cnt_q != '0) mul_cnt_d = mul_cnt_q - CNT_W'(1);
            default: mul_cnt_d = mul_cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q     <= IDLE;
            burst_cnt_q <= '0;
            last_op_q   <= MUL;
            add_cnt_q   <= '0;
            mul_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            last_op_q   <= last_op_d;
            add_cnt_q   <= add_cnt_d;
            mul_cnt_q   <= mul_cnt_d;
        end
    end

    assign add_inflight_o = add_cnt_q;
    assign mul_inflight_o = mul_cnt_q;
    assign busy_o         = (state_q != IDLE) || (add_cnt_q != '0) || (mul_cnt_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_softex_addmul_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_softex_addmul_arbiter: directed bench for the add/mul datapath arbiter.  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_softex_addmul_arbiter;
    import softex_pkg::*;

    logic       clk = 1'b0;
    logic       rst_i, clear_i, enable_i, prio_mode_i;
    logic       add_req_i, mul_req_i, fma_ready_i, add_done_i, mul_done_i;
    operation_t prio_op_i, operation_o;
    logic       issue_en_o, busy_o;
    logic [1:0] add_inflight_o, mul_inflight_o;

    int   n_checks = 0;
    int   n_pass   = 0;
    logic prev_add = 1'b0;
    logic prev_mul = 1'b0;
    logic auto_done = 1'b0;

    softex_addmul_arbiter #(.MAX_BURST(4), .CREDITS(2)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .clear_i        (clear_i),
        .enable_i       (enable_i),
        .prio_mode_i    (prio_mode_i),
        .prio_op_i      (prio_op_i),
        .add_req_i      (add_req_i),
        .mul_req_i      (mul_req_i),
        .fma_ready_i    (fma_ready_i),
        .add_done_i     (add_done_i),
        .mul_done_i     (mul_done_i),
        .operation_o    (operation_o),
        .issue_en_o     (issue_en_o),
        .add_inflight_o (add_inflight_o),
        .mul_inflight_o (mul_inflight_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    // One clock: done pulses follow accepts of the previous cycle when auto_done is set.
    task automatic run_cycle(input logic force_add_done, input logic force_mul_done,
                             output logic aa, output logic am);
        @(posedge clk);
        #1;
        add_done_i = (auto_done & prev_add) | force_add_done;
        mul_done_i = (auto_done & prev_mul) | force_mul_done;
        #1;
        aa = issue_en_o & (operation_o == ADD) & add_req_i & fma_ready_i;
        am = issue_en_o & (operation_o == MUL) & mul_req_i & fma_ready_i;
        prev_add = aa;
        prev_mul = am;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_i = 1'b1; clear_i = 1'b0; enable_i = 1'b1; prio_mode_i = 1'b0; prio_op_i = ADD;
        add_req_i = 1'b0; mul_req_i = 1'b0; fma_ready_i = 1'b0;
        add_done_i = 1'b0; mul_done_i = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_i = 1'b0; prev_add = 1'b0; prev_mul = 1'b0; auto_done = 1'b0;
    endtask

    task automatic test_reset();
        logic aa, am;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            run_cycle(1'b0, 1'b0, aa, am);
            n_checks++;
            if ({operation_o, issue_en_o, busy_o, add_inflight_o, mul_inflight_o} !== 7'b0) begin
                $display("FAIL reset_idle cycle %0d: got op=%0d issue=%b busy=%b add=%0d mul=%0d, expected all zero",
                         k, operation_o, issue_en_o, busy_o, add_inflight_o, mul_inflight_o);
            end else n_pass++;
        end
        // Done pulse with nothing in flight must not wrap the counter.
        run_cycle(1'b1, 1'b1, aa, am);
        run_cycle(1'b0, 1'b0, aa, am);
        n_checks++;
        if ({add_inflight_o, mul_inflight_o, busy_o} !== 5'b0) begin
            $display("FAIL done_at_zero: got add=%0d mul=%0d busy=%b, expected 0 0 0",
                     add_inflight_o, mul_inflight_o, busy_o);
        end else n_pass++;
    endtask

    task automatic test_enable_low();
        logic aa, am;
        do_reset();
        enable_i = 1'b0; add_req_i = 1'b1; fma_ready_i = 1'b1;
        run_cycle(1'b0, 1'b0, aa, am);
        run_cycle(1'b0, 1'b0, aa, am);
        n_checks++;
        if ({issue_en_o, busy_o} !== 2'b00) begin
            $display("FAIL enable_low_hold: got issue=%b busy=%b, expected 0 0", issue_en_o, busy_o);
        end else n_pass++;
        enable_i = 1'b1;
        run_cycle(1'b0, 1'b0, aa, am);
        n_checks++;
        if ({operation_o, issue_en_o} !== {ADD, 1'b1}) begin
            $display("FAIL enable_high_grant: got op=%0d issue=%b, expected 0 1", operation_o, issue_en_o);
        end else n_pass++;
    endtask

    task automatic test_round_robin();
        logic aa, am, exp_add;
        do_reset();
        auto_done = 1'b1;
        add_req_i = 1'b1; mul_req_i = 1'b1; fma_ready_i = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            run_cycle(1'b0, 1'b0, aa, am);
            exp_add = (((k - 1) / 4) % 2) == 0;
            n_checks++;
            if ({aa, am} !== {exp_add, ~exp_add}) begin
                $display("FAIL rr_burst cycle %0d: got add_acc=%b mul_acc=%b, expected %b %b",
                         k, aa, am, exp_add, ~exp_add);
            end else n_pass++;
        end
    endtask

    task automatic test_credits();
        logic aa, am;
        int   n_acc;
        do_reset();
        enable_i = 1'b1; add_req_i = 1'b1; fma_ready_i = 1'b1;
        n_acc = 0;
        for (int k = 1; k <= 4; k++) begin
            run_cycle(1'b0, 1'b0, aa, am);
            n_acc += int'(aa);
        end
        n_checks++;
        if (n_acc !== 2) begin
            $display("FAIL credit_accepts: got %0d accepts, expected 2", n_acc);
        end else n_pass++;
        n_checks++;
        if ({operation_o, issue_en_o, add_inflight_o, busy_o} !== {ADD, 1'b0, 2'd2, 1'b1}) begin
            $display("FAIL credit_stall: got op=%0d issue=%b add=%0d busy=%b, expected 0 0 2 1",
                     operation_o, issue_en_o, add_inflight_o, busy_o);
        end else n_pass++;
        run_cycle(1'b1, 1'b0, aa, am);
        run_cycle(1'b0, 1'b0, aa, am);
        n_checks++;
        if ({add_inflight_o, issue_en_o, aa} !== {2'd1, 1'b1, 1'b1}) begin
            $display("FAIL credit_return: got add=%0d issue=%b acc=%b, expected 1 1 1",
                     add_inflight_o, issue_en_o, aa);
        end else n_pass++;
        run_cycle(1'b0, 1'b0, aa, am);
        n_checks++;
        if ({add_inflight_o, issue_en_o} !== {2'd2, 1'b0}) begin
            $display("FAIL credit_refill: got add=%0d issue=%b, expected 2 0", add_inflight_o, issue_en_o);
        end else n_pass++;

        // ADD credits exhausted: a pending MUL takes over.
        mul_req_i = 1'b1;
        run_cycle(1'b0, 1'b0, aa, am);
        n_checks++;
        if ({operation_o, issue_en_o, am} !== {MUL, 1'b1, 1'b1}) begin
            $display("FAIL credit_switch: got op=%0d issue=%b mul_acc=%b, expected 1 1 1",
                     operation_o, issue_en_o, am);
        end else n_pass++;
        run_cycle(1'b0, 1'b0, aa, am);
        n_checks++;
        if ({add_inflight_o, mul_inflight_o, am} !== {2'd2, 2'd1, 1'b1}) begin
            $display("FAIL switch_mul_run: got add=%0d mul=%0d mul_acc=%b, expected 2 1 1",
                     add_inflight_o, mul_inflight_o, am);
        end else n_pass++;
        run_cycle(1'b0, 1'b0, aa, am);
        n_checks++;
        if ({operation_o, issue_en_o, add_inflight_o, mul_inflight_o} !== {MUL, 1'b0, 2'd2, 2'd2}) begin
            $display("FAIL both_exhausted: got op=%0d issue=%b add=%0d mul=%0d, expected 1 0 2 2",
                     operation_o, issue_en_o, add_inflight_o, mul_inflight_o);
        end else n_pass++;
    endtask

    task automatic test_fixed_prio();
        logic aa, am;
        do_reset();
        auto_done = 1'b1;
        prio_mode_i = 1'b1; prio_op_i = MUL;
        add_req_i = 1'b1; mul_req_i = 1'b1; fma_ready_i = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            run_cycle(1'b0, 1'b0, aa, am);
            n_checks++;
            if ({aa, am} !== 2'b01) begin
                $display("FAIL fixed_prio cycle %0d: got add_acc=%b mul_acc=%b, expected 0 1", k, aa, am);
            end else n_pass++;
        end
        mul_req_i = 1'b0;
        run_cycle(1'b0, 1'b0, aa, am);
        n_checks++;
        if ({operation_o, issue_en_o, aa} !== {ADD, 1'b1, 1'b1}) begin
            $display("FAIL prio_drop: got op=%0d issue=%b add_acc=%b, expected 0 1 1",
                     operation_o, issue_en_o, aa);
        end else n_pass++;
    endtask

    task automatic test_handshake_clear();
        logic aa, am;
        do_reset();
        add_req_i = 1'b1; mul_req_i = 1'b1; fma_ready_i = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            run_cycle(1'b0, 1'b0, aa, am);
            n_checks++;
            if ({operation_o, issue_en_o} !== {ADD, 1'b1}) begin
                $display("FAIL hs_stable cycle %0d: got op=%0d issue=%b, expected 0 1", k, operation_o, issue_en_o);
            end else n_pass++;
        end
        fma_ready_i = 1'b1;
        run_cycle(1'b0, 1'b0, aa, am);
        fma_ready_i = 1'b0;
        run_cycle(1'b0, 1'b0, aa, am);
        n_checks++;
        if ({add_inflight_o, busy_o} !== {2'd1, 1'b1}) begin
            $display("FAIL pre_clear: got add=%0d busy=%b, expected 1 1", add_inflight_o, busy_o);
        end else n_pass++;
        clear_i = 1'b1;
        run_cycle(1'b0, 1'b0, aa, am);
        clear_i = 1'b0;
        n_checks++;
        if ({operation_o, issue_en_o, busy_o, add_inflight_o, mul_inflight_o} !== 7'b0) begin
            $display("FAIL clear: got op=%0d issue=%b busy=%b add=%0d mul=%0d, expected all zero",
                     operation_o, issue_en_o, busy_o, add_inflight_o, mul_inflight_o);
        end else n_pass++;
    endtask

    initial begin
        test_reset();
        test_enable_low();
        test_round_robin();
        test_credits();
        test_fixed_prio();
        test_handshake_clear();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
